// File: rtl/cva6_shim_pkg.sv
// Shared constants, types and helpers for the cva6_processor_shim RV32I stand-in.
package cva6_shim_pkg;

  localparam int unsigned NUM_REGS  = 32;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned MEM_WORDS = 32;
  localparam int unsigned SB_DEPTH  = 2;

  localparam int unsigned REG_AW   = $clog2(NUM_REGS);
  localparam int unsigned IDX_W    = $clog2(MEM_WORDS);
  localparam int unsigned SB_PTR_W = (SB_DEPTH > 1) ? $clog2(SB_DEPTH) : 1;
  localparam int unsigned SB_CNT_W = $clog2(SB_DEPTH + 1);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;
  localparam logic [2:0] F3_W    = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic {IDLE, LOAD_WAIT} state_e;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic [XLEN-1:0]  data;
  } sb_entry_t;

  function automatic logic [SB_PTR_W-1:0] sb_ptr_inc(input logic [SB_PTR_W-1:0] p);
    return (32'(p) == SB_DEPTH - 1) ? '0 : p + SB_PTR_W'(1);
  endfunction

endpackage

// File: rtl/cva6_shim_store_buffer.sv
// Circular store-buffer FIFO with push/pop and youngest-match forwarding lookup.
module cva6_shim_store_buffer
  import cva6_shim_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  sb_entry_t        push_entry_i,
  input  logic             pop_i,
  input  logic [IDX_W-1:0] lookup_idx_i,
  output logic             empty_o,
  output logic             full_next_c_o,
  output sb_entry_t        head_c_o,
  output logic             fwd_hit_c_o,
  output logic [XLEN-1:0]  fwd_data_c_o
);

  sb_entry_t             entries_q [SB_DEPTH];
  logic [SB_PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [SB_PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [SB_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  empty_q;
  logic                  do_push, do_pop;
  logic [SB_PTR_W-1:0]   slot;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != SB_CNT_W'(SB_DEPTH)) || do_pop);

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = sb_ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = sb_ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + SB_CNT_W'(1);
      2'b01:   cnt_d = cnt_q - SB_CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      empty_q  <= 1'b1;
      for (int i = 0; i < int'(SB_DEPTH); i++) entries_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      empty_q  <= (cnt_d == '0);
      if (do_push) entries_q[wr_ptr_q] <= push_entry_i;
    end
  end

  assign empty_o       = empty_q;
  assign full_next_c_o = (cnt_d == SB_CNT_W'(SB_DEPTH));
  assign head_c_o      = entries_q[rd_ptr_q];

  // Walk oldest-to-youngest so the last match wins
  always_comb begin
    fwd_hit_c_o  = 1'b0;
    fwd_data_c_o = '0;
    slot         = '0;
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      slot = SB_PTR_W'((32'(rd_ptr_q) + i) % SB_DEPTH);
      if ((SB_CNT_W'(i) < cnt_q) && (entries_q[slot].index == lookup_idx_i)) begin
        fwd_hit_c_o  = 1'b1;
        fwd_data_c_o = entries_q[slot].data;
      end
    end
  end

endmodule

// File: rtl/cva6_processor_shim.sv
// In-order RV32I shim: one-cycle ALU ops, LW/SW through a word memory and store buffer.
// Optional EXPOSE_STATE_EN adds regfile_o/mem_o mirrors of architectural state.
module cva6_processor_shim
  import cva6_shim_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [31:0]               instr_i,
  input  logic                      instr_valid_i,
  output logic                      instr_ready_o,
  input  logic                      store_mem_resp_i,
  input  logic                      load_mem_resp_i
`ifdef EXPOSE_STATE_EN
  ,
  output logic [NUM_REGS*XLEN-1:0]  regfile_o,
  output logic [MEM_WORDS*XLEN-1:0] mem_o
`endif
);

  logic [XLEN-1:0]   rf_q  [NUM_REGS];
  logic [XLEN-1:0]   mem_q [MEM_WORDS];
  state_e            state_q, state_d;
  logic              ready_q, ready_d;
  logic [IDX_W-1:0]  ld_idx_q, ld_idx_d;
  logic [REG_AW-1:0] ld_rd_q, ld_rd_d;

  logic [6:0]        opcode, f7;
  logic [2:0]        f3;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [XLEN-1:0]   rs1_val, rs2_val, imm_i, imm_s, imm_u, addr;
  logic [IDX_W-1:0]  addr_idx;
  logic              accept, is_lw, is_sw;
  logic              alu_we;
  logic [XLEN-1:0]   alu_res;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata, load_data;

  logic              sb_empty, sb_full_next, sb_hit, sb_pop;
  sb_entry_t         sb_head;
  logic [XLEN-1:0]   sb_fwd_data;

  assign opcode  = instr_i[6:0];
  assign rd      = instr_i[11:7];
  assign f3      = instr_i[14:12];
  assign rs1     = instr_i[19:15];
  assign rs2     = instr_i[24:20];
  assign f7      = instr_i[31:25];
  assign imm_i   = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign imm_s   = {{(XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u   = {instr_i[31:12], 12'b0};
  assign rs1_val = rf_q[rs1];
  assign rs2_val = rf_q[rs2];

  assign accept   = instr_valid_i && ready_q;
  assign is_lw    = (opcode == LOAD) && (f3 == F3_W);
  assign is_sw    = (opcode == STORE) && (f3 == F3_W);
  assign addr     = rs1_val + (is_sw ? imm_s : imm_i);
  assign addr_idx = IDX_W'(addr >> 2);
  assign sb_pop   = store_mem_resp_i && !sb_empty;

  // ALU; unsupported encodings leave alu_we low and retire as NOP
  always_comb begin
    alu_we  = 1'b0;
    alu_res = '0;
    case (opcode)
      OP_IMM: begin
        alu_we = 1'b1;
        case (f3)
          F3_ADD:  alu_res = rs1_val + imm_i;
          F3_SLT:  alu_res = XLEN'($signed(rs1_val) < $signed(imm_i));
          F3_SLTU: alu_res = XLEN'(rs1_val < imm_i);
          F3_XOR:  alu_res = rs1_val ^ imm_i;
          F3_OR:   alu_res = rs1_val | imm_i;
          F3_AND:  alu_res = rs1_val & imm_i;
          F3_SLL: begin
            alu_we  = (f7 == F7_BASE);
            alu_res = rs1_val << rs2;
          end
          default: begin
            alu_we  = (f7 == F7_BASE) || (f7 == F7_ALT);
            alu_res = (f7 == F7_ALT) ? XLEN'($signed(rs1_val) >>> rs2) : (rs1_val >> rs2);
          end
        endcase
      end
      OP: begin
        alu_we = 1'b1;
        case ({f7, f3})
          {F7_BASE, F3_ADD}:  alu_res = rs1_val + rs2_val;
          {F7_ALT,  F3_ADD}:  alu_res = rs1_val - rs2_val;
          {F7_BASE, F3_SLL}:  alu_res = rs1_val << rs2_val[4:0];
          {F7_BASE, F3_SLT}:  alu_res = XLEN'($signed(rs1_val) < $signed(rs2_val));
          {F7_BASE, F3_SLTU}: alu_res = XLEN'(rs1_val < rs2_val);
          {F7_BASE, F3_XOR}:  alu_res = rs1_val ^ rs2_val;
          {F7_BASE, F3_SR}:   alu_res = rs1_val >> rs2_val[4:0];
          {F7_ALT,  F3_SR}:   alu_res = XLEN'($signed(rs1_val) >>> rs2_val[4:0]);
          {F7_BASE, F3_OR}:   alu_res = rs1_val | rs2_val;
          {F7_BASE, F3_AND}:  alu_res = rs1_val & rs2_val;
          default:            alu_we  = 1'b0;
        endcase
      end
      LUI: begin
        alu_we  = 1'b1;
        alu_res = imm_u;
      end
      default: alu_we = 1'b0;
    endcase
  end

  assign load_data = sb_hit ? sb_fwd_data : mem_q[ld_idx_q];

  // Single regfile write port shared by ALU retire and load completion
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (accept && alu_we) begin
      rf_we    = 1'b1;
      rf_waddr = rd;
      rf_wdata = alu_res;
    end else if ((state_q == LOAD_WAIT) && load_mem_resp_i) begin
      rf_we    = 1'b1;
      rf_waddr = ld_rd_q;
      rf_wdata = load_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    ld_idx_d = ld_idx_q;
    ld_rd_d  = ld_rd_q;
    case (state_q)
      IDLE: begin
        if (accept && is_lw) begin
          state_d  = LOAD_WAIT;
          ld_idx_d = addr_idx;
          ld_rd_d  = rd;
        end
      end
      LOAD_WAIT: begin
        if (load_mem_resp_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE) && !sb_full_next;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      ld_idx_q <= '0;
      ld_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      ld_idx_q <= ld_idx_d;
      ld_rd_q  <= ld_rd_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_REGS); i++) rf_q[i] <= '0;
    end else if (rf_we && (rf_waddr != '0)) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) mem_q[i] <= '0;
    end else if (sb_pop) begin
      mem_q[sb_head.index] <= sb_head.data;
    end
  end

  cva6_shim_store_buffer u_sb (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (accept && is_sw),
    .push_entry_i  ('{index: addr_idx, data: rs2_val}),
    .pop_i         (sb_pop),
    .lookup_idx_i  (ld_idx_q),
    .empty_o       (sb_empty),
    .full_next_c_o (sb_full_next),
    .head_c_o      (sb_head),
    .fwd_hit_c_o   (sb_hit),
    .fwd_data_c_o  (sb_fwd_data)
  );

  assign instr_ready_o = ready_q;

`ifdef EXPOSE_STATE_EN
  always_comb begin
    regfile_o = '0;
    mem_o     = '0;
    for (int i = 0; i < int'(NUM_REGS); i++)  regfile_o[XLEN*i +: XLEN] = rf_q[i];
    for (int i = 0; i < int'(MEM_WORDS); i++) mem_o[XLEN*i +: XLEN]     = mem_q[i];
  end
`endif

endmodule

// File: tb/tb_cva6_processor_shim.sv
// Directed bench for cva6_processor_shim: ALU ops, store buffering/drain, forwarding, load pacing, reset.
module tb_cva6_processor_shim;

  logic        clk;
  logic        rst_n;
  logic [31:0] instr;
  logic        valid;
  logic        ready;
  logic        sresp;
  logic        lresp;
  int          n_tests;
  int          n_fail;
  int          lowcnt;

`ifdef EXPOSE_STATE_EN
  logic [32*32-1:0] regfile_w;
  logic [32*32-1:0] mem_w;
`endif

  cva6_processor_shim dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .instr_i          (instr),
    .instr_valid_i    (valid),
    .instr_ready_o    (ready),
    .store_mem_resp_i (sresp),
    .load_mem_resp_i  (lresp)
`ifdef EXPOSE_STATE_EN
    ,
    .regfile_o        (regfile_w),
    .mem_o            (mem_w)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    instr = ins;
    valid = 1'b1;
    step();
    valid = 1'b0;
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction

  localparam logic [6:0] OPI = 7'b0010011;
  localparam logic [6:0] LDO = 7'b0000011;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    valid   = 1'b0;
    instr   = 32'h0;
    sresp   = 1'b0;
    lresp   = 1'b0;

    repeat (2) step();
    check("ready_in_reset", 32'(ready), 32'd0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", 32'(ready), 32'd1);
    check("rst_x1", dut.rf_q[1], 32'd0);

    // ALU basics and x0
    issue(enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI));
    check("addi_x1", dut.rf_q[1], 32'd5);
    check("addi_ready", 32'(ready), 32'd1);
    issue(enc_i(12'd7, 5'd0, 3'b000, 5'd0, OPI));
    check("x0_zero", dut.rf_q[0], 32'd0);
    issue(enc_i(12'd8, 5'd0, 3'b000, 5'd2, OPI));
    check("addi_x2", dut.rf_q[2], 32'd8);

    // Stores stay buffered until drained
    issue(enc_sw(12'd0, 5'd1, 5'd2));
    check("sw1_mem_undrained", dut.mem_q[2], 32'd0);
    check("sw1_ready", 32'(ready), 32'd1);
    issue(enc_i(12'd9, 5'd0, 3'b000, 5'd1, OPI));
    check("x1_9", dut.rf_q[1], 32'd9);
    issue(enc_sw(12'd0, 5'd1, 5'd2));
    check("sb_full_ready", 32'(ready), 32'd0);
    step();
    check("sb_full_hold", 32'(ready), 32'd0);
    check("sb_full_mem", dut.mem_q[2], 32'd0);
    sresp = 1'b1;
    step();
    sresp = 1'b0;
    check("drain1_mem", dut.mem_q[2], 32'd5);
    check("drain1_ready", 32'(ready), 32'd1);

    // Load between drains forwards youngest buffered value
    lresp = 1'b1;
    issue(enc_i(12'd0, 5'd2, 3'b010, 5'd3, LDO));
    check("lw_fwd_busy", 32'(ready), 32'd0);
    check("lw_fwd_pre", dut.rf_q[3], 32'd0);
    step();
    lresp = 1'b0;
    check("lw_fwd_x3", dut.rf_q[3], 32'd9);
    check("lw_fwd_ready", 32'(ready), 32'd1);
    sresp = 1'b1;
    step();
    sresp = 1'b0;
    check("drain2_mem", dut.mem_q[2], 32'd9);
    step();
    check("drain_empty_ready", 32'(ready), 32'd1);

    // Load paced by delayed response
    issue(enc_i(12'd0, 5'd2, 3'b010, 5'd4, LDO));
    lowcnt = 0;
    for (int c = 0; c < 20 && !ready; c++) begin
      lowcnt++;
      if (lowcnt == 4) begin
        check("lw_not_early", dut.rf_q[4], 32'd0);
        lresp = 1'b1;
      end
      step();
    end
    lresp = 1'b0;
    check("lw_delay_ready", 32'(ready), 32'd1);
    check("lw_delay_lowcnt", 32'(lowcnt), 32'd4);
    check("lw_delay_x4", dut.rf_q[4], 32'd9);

    // ALU vectors
    issue(enc_i(12'hFFD, 5'd0, 3'b000, 5'd7, OPI));
    check("addi_neg", dut.rf_q[7], 32'hFFFF_FFFD);
    issue(enc_i({7'b0100000, 5'd1}, 5'd7, 3'b101, 5'd8, OPI));
    check("srai", dut.rf_q[8], 32'hFFFF_FFFE);
    issue(enc_i({7'b0000000, 5'd28}, 5'd7, 3'b101, 5'd9, OPI));
    check("srli", dut.rf_q[9], 32'h0000_000F);
    issue(enc_r(7'b0000000, 5'd1, 5'd7, 3'b010, 5'd10));
    check("slt", dut.rf_q[10], 32'd1);
    issue(enc_r(7'b0000000, 5'd1, 5'd7, 3'b011, 5'd11));
    check("sltu", dut.rf_q[11], 32'd0);
    issue(enc_r(7'b0100000, 5'd7, 5'd1, 3'b000, 5'd12));
    check("sub", dut.rf_q[12], 32'd12);
    issue({20'h12345, 5'd13, 7'b0110111});
    check("lui", dut.rf_q[13], 32'h1234_5000);
    issue(enc_i(12'h0FF, 5'd1, 3'b100, 5'd14, OPI));
    check("xori", dut.rf_q[14], 32'h0000_00F6);
    issue(enc_i({7'b0000000, 5'd31}, 5'd1, 3'b001, 5'd16, OPI));
    check("slli", dut.rf_q[16], 32'h8000_0000);
    issue({7'b0, 5'd0, 5'd0, 3'b000, 5'd15, 7'b1100011});
    check("branch_nop_rd", dut.rf_q[15], 32'd0);
    check("branch_nop_ready", 32'(ready), 32'd1);

    // Reset while a load is outstanding
    issue(enc_i(12'd0, 5'd2, 3'b010, 5'd17, LDO));
    check("rst_ld_busy", 32'(ready), 32'd0);
    rst_n = 1'b0;
    lresp = 1'b1;
    #1;
    check("rst_ld_x1", dut.rf_q[1], 32'd0);
    check("rst_ld_mem", dut.mem_q[2], 32'd0);
    check("rst_ld_ready", 32'(ready), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("rst_rel_ready", 32'(ready), 32'd1);
    check("rst_rel_x17", dut.rf_q[17], 32'd0);
    step();
    lresp = 1'b0;
    check("rst_drop_x17", dut.rf_q[17], 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
